// File: rtl/core_pkg.sv
// Shared core constants: xmem geometry, inst[] bit positions for the xmem strobes,
// and the xmem loader state encoding.
package core_pkg;

  localparam int XMEM_AW        = 11;
  localparam int XMEM_WORD_BW   = 32;
  localparam int INST_CEN_XMEM  = 19;
  localparam int INST_WEN_XMEM  = 18;
  localparam int INST_A_XMEM_HI = 17;
  localparam int INST_A_XMEM_LO = 7;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/xmem_addr_gen.sv
// xmem loader address/count generator: loads base on start, increments with wrap per write.
// Latency: addr/cnt update on the edge after step; term is combinational from cnt.
// Backpressure: none; advances only when step is asserted.
module xmem_addr_gen #(
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [addr_bw-1:0] base,
  input  logic [addr_bw:0]   length,
  output logic [addr_bw-1:0] addr,
  output logic [addr_bw:0]   cnt,
  output logic               term
);

  logic [addr_bw:0] len_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr  <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (load) begin
      addr  <= base;
      cnt   <= '0;
      len_q <= length;
    end else if (step) begin
      // Address width is exactly log2(depth), so natural overflow is the wrap.
      addr <= addr + addr_bw'(1);
      cnt  <= cnt + (addr_bw + 1)'(1);
    end
  end

  // High while the next accepted word is the final one of the requested length.
  assign term = ((cnt + (addr_bw + 1)'(1)) == len_q);

endmodule

// File: rtl/xmem_loader.sv
// Streams a valid/ready word burst into xmem as registered CEN/WEN/A/D strobes (XMEM_LOADER_CHKSUM_EN adds chksum).
// Latency: one cycle from accept to write strobe; done pulses the cycle after the final accept.
// Backpressure: in_ready only in LOAD and low while hold requests xmem for the core.
module xmem_loader
  import core_pkg::*;
#(
  parameter int bw      = 4,
  parameter int row     = 8,
  parameter int addr_bw = XMEM_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_bw-1:0]  base_addr,
  input  logic [addr_bw:0]    length,
  input  logic                hold,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bw*row-1:0]   in_data,
  input  logic                in_last,
  output logic                CEN_xmem,
  output logic                WEN_xmem,
  output logic [addr_bw-1:0]  A_xmem,
  output logic [bw*row-1:0]   D_xmem,
  output logic                busy,
  output logic                done,
  output logic                short_err
`ifdef XMEM_LOADER_CHKSUM_EN
  ,
  output logic [bw*row-1:0]   chksum
`endif
);

  ld_state_t          state, state_nxt;
  logic               start_ok;
  logic               accept;
  logic [addr_bw-1:0] addr;
  logic [addr_bw:0]   cnt;
  logic               term;

  assign start_ok = start & (state == LD_IDLE);
  assign in_ready = (state == LD_LOAD) & ~hold;
  assign accept   = in_valid & in_ready;
  assign busy     = (state != LD_IDLE);
  assign done     = (state == LD_DONE);

  xmem_addr_gen #(.addr_bw(addr_bw)) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (start_ok),
    .step   (accept),
    .base   (base_addr),
    .length (length),
    .addr   (addr),
    .cnt    (cnt),
    .term   (term)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= LD_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE: if (start) state_nxt = (length == '0) ? LD_DONE : LD_LOAD;
      LD_LOAD: if (accept && (term || in_last)) state_nxt = LD_DONE;
      LD_DONE: state_nxt = LD_IDLE;
      default: state_nxt = LD_IDLE;
    endcase
  end

  // Strobes are registered; A/D keep their last value between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      CEN_xmem <= 1'b1;
      WEN_xmem <= 1'b1;
      A_xmem   <= '0;
      D_xmem   <= '0;
    end else begin
      CEN_xmem <= ~accept;
      WEN_xmem <= ~accept;
      if (accept) begin
        A_xmem <= addr;
        D_xmem <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                            short_err <= 1'b0;
    else if (start_ok)                    short_err <= 1'b0;
    else if (accept && in_last && !term)  short_err <= 1'b1;
  end

`ifdef XMEM_LOADER_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)         chksum <= '0;
    else if (start_ok) chksum <= '0;
    else if (accept)   chksum <= chksum ^ in_data;
  end
`endif

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_xmem_loader.sv
// Randomized self-checking bench for xmem_loader against a transaction-level reference model.
module tb_xmem_loader;

  localparam int AW = 11;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          reset, start, hold, in_valid, in_last;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [W-1:0]  in_data;
  logic          in_ready, CEN_xmem, WEN_xmem, busy, done, short_err;
  logic [AW-1:0] A_xmem;
  logic [W-1:0]  D_xmem;
`ifdef XMEM_LOADER_CHKSUM_EN
  logic [W-1:0]  chksum;
`endif

  xmem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .hold      (hold),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .CEN_xmem  (CEN_xmem),
    .WEN_xmem  (WEN_xmem),
    .A_xmem    (A_xmem),
    .D_xmem    (D_xmem),
    .busy      (busy),
    .done      (done),
    .short_err (short_err)
`ifdef XMEM_LOADER_CHKSUM_EN
    ,
    .chksum    (chksum)
`endif
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] mem    [0:2047];
  int           wr_cnt [0:2047];
  logic [W-1:0] src    [0:2199];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One load: reference expects min(len, last_idx+1) writes to (base+i) mod 2048, in order.
  // hold_mode: 0 none, 1 hold on LOAD cycles 2-3, 2 random.
  task automatic run_load(input int b, input int l, input int last_idx, input int hold_mode,
                          input bit pat, input bit rnd_valid, input bit mid_start);
    int            exp_n, k, c;
    bit            acc, seen_done;
    logic [W-1:0]  xsum;
    logic [AW-1:0] ea;
    exp_n = (last_idx >= 0 && last_idx + 1 < l) ? last_idx + 1 : l;
    for (int i = 0; i < l + 4; i++) src[i] = pat ? W'(i + 1) * 32'h11111111 : W'($urandom);
    start = 1'b1; base_addr = AW'(b); length = (AW+1)'(l);
    in_valid = 1'b0; hold = 1'b0; in_last = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(l != 0 ? 1 : 1));
    check("short_err_cleared", 64'(short_err), 64'd0);
    k = 0; c = 0; xsum = '0; seen_done = 1'b0;
    while (!seen_done && c < 6000) begin
      if (done) begin
        seen_done = 1'b1;
        check("done_after_last", 64'(k), 64'(exp_n));
      end else begin
        hold     = (hold_mode == 1) ? (c == 1 || c == 2) :
                   (hold_mode == 2) ? ($urandom_range(3) == 0) : 1'b0;
        in_valid = rnd_valid ? ($urandom_range(3) != 0) : 1'b1;
        in_data  = src[k];
        in_last  = (k == last_idx);
        start    = mid_start && ($urandom_range(7) == 0);
        base_addr = AW'($urandom); length = (AW+1)'($urandom);
        #1;
        acc = in_valid && in_ready;
        if (hold) check("ready_low_on_hold", 64'(in_ready), 64'd0);
        ea = AW'(b + k);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check("cen_follows_accept", 64'(CEN_xmem), 64'(!acc));
        check("wen_follows_accept", 64'(WEN_xmem), 64'(!acc));
        if (acc) begin
          check("write_addr", 64'(A_xmem), 64'(ea));
          check("write_data", 64'(D_xmem), 64'(src[k]));
          mem[A_xmem] = D_xmem;
          wr_cnt[A_xmem]++;
          xsum ^= src[k];
          k++;
        end
        c++;
      end
    end
    if (!seen_done) check("done_timeout", 64'd0, 64'd1);
    in_valid = 1'b1; hold = 1'b0; in_last = 1'b0;
    #1;
    check("no_accept_in_done", 64'(in_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("done_one_cycle", 64'(done), 64'd0);
    check("no_extra_write", 64'(CEN_xmem), 64'd1);
    check("idle_not_busy", 64'(busy), 64'd0);
    check("short_err", 64'(short_err), 64'(exp_n < l));
    check("accepted_count", 64'(k), 64'(exp_n));
`ifdef XMEM_LOADER_CHKSUM_EN
    check("chksum", 64'(chksum), 64'(xsum));
`endif
  endtask

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0; hold = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    base_addr = '0; length = '0; in_data = '0;
    for (int i = 0; i < 2048; i++) wr_cnt[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cen", 64'(CEN_xmem), 64'd1);
    check("rst_wen", 64'(WEN_xmem), 64'd1);
    check("rst_a", 64'(A_xmem), 64'd0);
    check("rst_d", 64'(D_xmem), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_short_err", 64'(short_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_load(0, 4, -1, 0, 1'b1, 1'b0, 1'b0);
    run_load(2046, 4, -1, 0, 1'b0, 1'b0, 1'b0);
    check("readback_2046", 64'(mem[2046]), 64'(src[0]));
    check("readback_2047", 64'(mem[2047]), 64'(src[1]));
    check("readback_0", 64'(mem[0]), 64'(src[2]));
    check("readback_1", 64'(mem[1]), 64'(src[3]));
    run_load(37, 6, -1, 1, 1'b0, 1'b0, 1'b0);
    run_load(500, 8, 4, 0, 1'b0, 1'b0, 1'b0);
    run_load(600, 3, 2, 0, 1'b0, 1'b0, 1'b1);
    run_load(9, 0, -1, 0, 1'b0, 1'b0, 1'b0);
    run_load(700, 12, -1, 0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 2048; i++) wr_cnt[i] = 0;
    run_load(int'($urandom_range(2047)), 2048, -1, 2, 1'b0, 1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 2048; i++) if (wr_cnt[i] != 1) bad++;
    check("full_depth_each_once", 64'(bad), 64'd0);

    for (int it = 0; it < 40; it++) begin
      int l, li;
      l  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 20));
      li = ($urandom_range(2) == 0) ? int'($urandom_range(0, l + 2)) : -1;
      run_load(int'($urandom_range(2047)), l, li, 2, 1'b0, 1'b1, 1'b1);
    end

    start = 1'b1; base_addr = 11'd100; length = 12'd8; hold = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = W'($urandom);
      @(posedge clk); @(negedge clk);
    end
    in_data = 32'hDEADBEEF;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mid_reset_cen", 64'(CEN_xmem), 64'd1);
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_ready", 64'(in_ready), 64'd0);
    check("mid_reset_a", 64'(A_xmem), 64'd0);
`ifdef XMEM_LOADER_CHKSUM_EN
    check("mid_reset_chksum", 64'(chksum), 64'd0);
`endif
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_reset_idle_cen", 64'(CEN_xmem), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
